map_requester: RTL

MAP_REQUESTER -- requirements
Module: map_requester

---
 rtl/map_pkg.sv | 32 +++
 rtl/map_cmd_fifo.sv | 60 ++++++
 rtl/map_requester.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/map_pkg.sv
// Shared encodings for the map requester: command ops, response status,
// requester FSM states and the saturating counter helper.
package map_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_LOOKUP = 2'd3
    } map_op_e;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_MISS = 2'd1,
        ST_FULL = 2'd2
    } map_status_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_COMMIT = 2'd2,
        S_RESP   = 2'd3
    } map_state_e;

    localparam int CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/map_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of 2), pointers wrap naturally.
// Push is ignored when full, pop is ignored when empty.
module map_cmd_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next pointers and occupancy; simultaneous push+pop leaves count alone.
    always_comb begin
        wr_d  = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d  = pop_ok  ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer/occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/map_requester.sv
// Serialises host map commands: buffers them in a FIFO, issues one at a
// time to the map (DELETE is a LOOKUP probe followed by a commit cycle),
// and returns a registered response held until the host accepts it.
module map_requester
    import map_pkg::*;
#(
    parameter int KEY_WIDTH   = 8,
    parameter int VALUE_WIDTH = 16,
    parameter int CMD_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [KEY_WIDTH-1:0]   cmd_key,
    input  logic [VALUE_WIDTH-1:0] cmd_value,
    output logic [KEY_WIDTH-1:0]   map_key,
    output logic [VALUE_WIDTH-1:0] map_value,
    output logic [1:0]             map_op,
    output logic                   map_valid,
    input  logic                   map_ready,
    input  logic [VALUE_WIDTH-1:0] map_rsp_value,
    input  logic                   map_rsp_valid,
    output logic                   map_rsp_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_op,
    output logic [1:0]             rsp_status,
    output logic [VALUE_WIDTH-1:0] rsp_value,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
);
    localparam int FW = 2 + KEY_WIDTH + VALUE_WIDTH;

    logic          fifo_full, fifo_empty, fifo_pop;
    logic [FW-1:0] fifo_rdata;

    map_state_e             state_q, state_d;
    map_op_e                cur_op_q, cur_op_d;
    logic [KEY_WIDTH-1:0]   cur_key_q, cur_key_d;
    logic [VALUE_WIDTH-1:0] cur_val_q, cur_val_d;
    map_op_e                rsp_op_q, rsp_op_d;
    map_status_e            rsp_status_q, rsp_status_d;
    logic [VALUE_WIDTH-1:0] rsp_value_q, rsp_value_d;
    logic [CNT_W-1:0]       hit_q, hit_d, miss_q, miss_d;
    logic                   mv_c, mrr_c;
    map_op_e                mop_c;

    map_cmd_fifo #(.WIDTH(FW), .DEPTH(CMD_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (cmd_valid),
        .data_i  ({cmd_op, cmd_key, cmd_value}),
        .full_o  (fifo_full),
        .pop_i   (fifo_pop),
        .empty_o (fifo_empty),
        .data_o  (fifo_rdata)
    );

    assign cmd_ready = !fifo_full;

    // Requester FSM: pop, issue/probe, optional delete commit, hold response.
    always_comb begin
        state_d      = state_q;
        cur_op_d     = cur_op_q;
        cur_key_d    = cur_key_q;
        cur_val_d    = cur_val_q;
        rsp_op_d     = rsp_op_q;
        rsp_status_d = rsp_status_q;
        rsp_value_d  = rsp_value_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        fifo_pop     = 1'b0;
        mv_c         = 1'b0;
        mrr_c        = 1'b0;
        mop_c        = OP_NOP;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    cur_op_d  = map_op_e'(fifo_rdata[FW-1 -: 2]);
                    cur_key_d = fifo_rdata[VALUE_WIDTH +: KEY_WIDTH];
                    cur_val_d = fifo_rdata[VALUE_WIDTH-1:0];
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mv_c         = 1'b1;
                mrr_c        = 1'b1;
                mop_c        = (cur_op_q == OP_DELETE) ? OP_LOOKUP : cur_op_q;
                rsp_op_d     = cur_op_q;
                rsp_status_d = ST_OK;
                rsp_value_d  = '0;
                state_d      = S_RESP;
                case (cur_op_q)
                    OP_INSERT: if (!map_ready) rsp_status_d = ST_FULL;
                    OP_LOOKUP: begin
                        if (map_rsp_valid) begin
                            rsp_value_d = map_rsp_value;
                            hit_d       = sat_inc(hit_q);
                        end else begin
                            rsp_status_d = ST_MISS;
                            miss_d       = sat_inc(miss_q);
                        end
                    end
                    OP_DELETE: begin
                        if (map_rsp_valid) begin
                            hit_d   = sat_inc(hit_q);
                            state_d = S_COMMIT;
                        end else begin
                            rsp_status_d = ST_MISS;
                            miss_d       = sat_inc(miss_q);
                        end
                    end
                    default: ;
                endcase
            end
            S_COMMIT: begin
                mv_c         = 1'b1;
                mop_c        = OP_DELETE;
                rsp_status_d = ST_OK;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, current command and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rsp_op_q     <= OP_NOP;
            rsp_status_q <= ST_OK;
            rsp_value_q  <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            rsp_op_q     <= rsp_op_d;
            rsp_status_q <= rsp_status_d;
            rsp_value_q  <= rsp_value_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    // Current-command payload is only meaningful after a pop; no reset needed.
    always_ff @(posedge clk) begin
        cur_op_q  <= cur_op_d;
        cur_key_q <= cur_key_d;
        cur_val_q <= cur_val_d;
    end

    // Reset kills any in-flight map request in the same cycle.
    assign map_valid     = mv_c && !reset;
    assign map_rsp_ready = mrr_c && !reset;
    assign map_op        = reset ? OP_NOP : mop_c;
    assign map_key       = cur_key_q;
    assign map_value     = cur_val_q;
    assign rsp_valid     = (state_q == S_RESP);
    assign rsp_op        = rsp_op_q;
    assign rsp_status    = rsp_status_q;
    assign rsp_value     = rsp_value_q;
    assign hit_count     = hit_q;
    assign miss_count    = miss_q;

endmodule
